// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receiver with a single-word holding register.
//
// Frames on rxd (idle high) are deserialized LSB first. Frame format (5..8 data bits,
// optional even/odd parity, one or two stop bits) is latched when the start bit is
// confirmed, so configuration changes mid-frame only affect the next frame.
// cfg_baud_div takes effect at the next tick reload.
//
// Optional build macro:
//   UART_RX_MAJORITY_EN - each bit is the 2-of-3 majority of ticks 7/8/9, decided at
//                         tick 9. Otherwise a single sample is taken at tick 8.
//
// Ports:
//   mclk, reset_n   system clock, synchronous active-low reset
//   rxd             asynchronous serial input
//   cfg_rx_en       receiver enable; low aborts any frame in progress
//   cfg_data_bits   data bits = value + 5
//   cfg_stop_bits   0: one stop bit, 1: two stop bits
//   cfg_par_en      parity bit present
//   cfg_even_par    1: even parity, 0: odd parity
//   cfg_baud_div    tick period = cfg_baud_div + 1 mclk cycles
//   rx_data         received word, unused upper bits zero
//   rx_valid        holding register full
//   rx_ready        consumer accepts the word when rx_valid & rx_ready
//   rx_par_err      parity error flag for the held word
//   rx_frm_err      stop-bit error flag for the held word
//   rx_overrun      sticky: a frame completed while rx_valid was set
//   err_clr         clears rx_overrun
//   rx_busy         receiver FSM not idle

module uart_rx_core #(
  parameter int unsigned DIV_W       = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             rxd,
  input  logic             cfg_rx_en,
  input  logic [1:0]       cfg_data_bits,
  input  logic             cfg_stop_bits,
  input  logic             cfg_par_en,
  input  logic             cfg_even_par,
  input  logic [DIV_W-1:0] cfg_baud_div,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_par_err,
  output logic             rx_frm_err,
  output logic             rx_overrun,
  input  logic             err_clr,
  output logic             rx_busy
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } state_e;

  // Synchronizer and edge detect
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_prev_q;
  logic                   rxd_s;

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // Tick generation
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [3:0]       btick_q, btick_d;  // ticks elapsed in the current bit (tick number - 1)

  // FSM and frame state
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_err_q, par_err_d;
  logic       frm_err_q, frm_err_d;
  logic [1:0] lat_bits_q, lat_bits_d;
  logic       lat_stop2_q, lat_stop2_d;
  logic       lat_par_en_q, lat_par_en_d;
  logic       lat_even_q, lat_even_d;

  // Holding register
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_par_q, hold_par_d;
  logic       hold_frm_q, hold_frm_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;

  logic start_det;
  logic sample_pt;
  logic bit_val;
  logic complete;
  logic last_data_bit;
  logic exp_par;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] SampleTick = 4'd8;  // tick 9 of the bit

  logic [1:0] maj_q, maj_d;  // samples from ticks 7 and 8

  always_comb begin
    maj_d = maj_q;
    if (tick && btick_q == 4'd6) maj_d[0] = rxd_s;
    if (tick && btick_q == 4'd7) maj_d[1] = rxd_s;
  end

  assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rxd_s) | (maj_q[1] & rxd_s);

  always_ff @(posedge mclk) begin
    if (!reset_n) maj_q <= '0;
    else          maj_q <= maj_d;
  end
`else
  localparam logic [3:0] SampleTick = 4'd7;  // tick 8 of the bit

  assign bit_val = rxd_s;
`endif

  assign start_det = (state_q == StIdle) && cfg_rx_en && rxd_prev_q && !rxd_s;
  assign tick      = (tick_cnt_q == '0);
  assign sample_pt = tick && (btick_q == SampleTick);

  // Data bit index of the final data bit is data_bits + 4
  assign last_data_bit = (bit_cnt_q == (3'd4 + {1'b0, lat_bits_q}));
  // Upper shift bits stay zero, so reducing all 8 bits is safe for short words
  assign exp_par       = lat_even_q ? ^shift_q : ~^shift_q;

  // Tick counter: free-runs, cleared on a start edge so bit timing aligns to it
  always_comb begin
    tick_cnt_d = tick_cnt_q - DIV_W'(1);
    if (start_det) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = cfg_baud_div;
    end
  end

  always_comb begin
    btick_d = btick_q;
    if (state_q == StIdle) begin
      btick_d = '0;
    end else if (tick) begin
      btick_d = btick_q + 4'd1;  // wraps 15 -> 0 at each bit boundary
    end
  end

  // FSM next state
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    frm_err_d    = frm_err_q;
    lat_bits_d   = lat_bits_q;
    lat_stop2_d  = lat_stop2_q;
    lat_par_en_d = lat_par_en_q;
    lat_even_d   = lat_even_q;
    complete     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_det) state_d = StStart;
      end
      StStart: begin
        if (sample_pt) begin
          if (!bit_val) begin
            state_d      = StData;
            bit_cnt_d    = '0;
            shift_d      = '0;
            par_err_d    = 1'b0;
            frm_err_d    = 1'b0;
            lat_bits_d   = cfg_data_bits;
            lat_stop2_d  = cfg_stop_bits;
            lat_par_en_d = cfg_par_en;
            lat_even_d   = cfg_even_par;
          end else begin
            state_d = StIdle;  // false start
          end
        end
      end
      StData: begin
        if (sample_pt) begin
          shift_d[bit_cnt_q] = bit_val;
          if (last_data_bit) begin
            state_d = lat_par_en_q ? StParity : StStop1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (sample_pt) begin
          par_err_d = (bit_val != exp_par);
          state_d   = StStop1;
        end
      end
      StStop1: begin
        if (sample_pt) begin
          if (!bit_val) frm_err_d = 1'b1;
          if (lat_stop2_q) begin
            state_d = StStop2;
          end else begin
            complete = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StStop2: begin
        if (sample_pt) begin
          if (!bit_val) frm_err_d = 1'b1;
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!cfg_rx_en) begin
      state_d  = StIdle;
      complete = 1'b0;
    end
  end

  // Holding register and handshake
  always_comb begin
    hold_data_d = hold_data_q;
    hold_par_d  = hold_par_q;
    hold_frm_d  = hold_frm_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;

    if (valid_q && rx_ready) valid_d = 1'b0;
    if (err_clr) overrun_d = 1'b0;

    if (complete) begin
      if (valid_q) begin
        // Old word wins even if it is being accepted this very cycle
        overrun_d = 1'b1;
      end else begin
        hold_data_d = shift_q;
        hold_par_d  = par_err_q;
        hold_frm_d  = frm_err_d;
        valid_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      sync_q       <= '1;
      rxd_prev_q   <= 1'b1;
      tick_cnt_q   <= '0;
      btick_q      <= '0;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      lat_bits_q   <= '0;
      lat_stop2_q  <= 1'b0;
      lat_par_en_q <= 1'b0;
      lat_even_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_par_q   <= 1'b0;
      hold_frm_q   <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxd_prev_q   <= rxd_s;
      tick_cnt_q   <= tick_cnt_d;
      btick_q      <= btick_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      frm_err_q    <= frm_err_d;
      lat_bits_q   <= lat_bits_d;
      lat_stop2_q  <= lat_stop2_d;
      lat_par_en_q <= lat_par_en_d;
      lat_even_q   <= lat_even_d;
      hold_data_q  <= hold_data_d;
      hold_par_q   <= hold_par_d;
      hold_frm_q   <= hold_frm_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = hold_data_q;
  assign rx_valid   = valid_q;
  assign rx_par_err = hold_par_q;
  assign rx_frm_err = hold_frm_q;
  assign rx_overrun = overrun_q;
  assign rx_busy    = (state_q != StIdle);

endmodule
